branch_predictor: RTL and testbench

//   Fetch-side dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 164 ++++++++++++++++
 tb/tb_branch_predictor.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Branch predictor pipeline interface.
// Carries the fetch PC, the pipeline stall/flush controls and the resolved
// branch from E into the predictor. It carries the fetch prediction and the
// E-stage redirect back out.
//   master : pipeline side (drives PC, controls, resolution)
//   slave  : predictor side (drives prediction and redirect)
interface branch_predictor_if #(
    parameter int PC_W = 32
);
    logic [PC_W-1:0] PCF;
    logic            StallD;
    logic            FlushD;
    logic            FlushE;
    logic            BranchE;
    logic            BranchTakenE;
    logic [PC_W-1:0] BranchTargetE;
    logic            PredTakenF;
    logic [PC_W-1:0] PredTargetF;
    logic            WrongPredictionE;
    logic [PC_W-1:0] CorrectPCE;

    modport master (
        output PCF, StallD, FlushD, FlushE, BranchE, BranchTakenE, BranchTargetE,
        input  PredTakenF, PredTargetF, WrongPredictionE, CorrectPCE
    );

    modport slave (
        input  PCF, StallD, FlushD, FlushE, BranchE, BranchTakenE, BranchTargetE,
        output PredTakenF, PredTargetF, WrongPredictionE, CorrectPCE
    );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor.
// The BTB is direct-mapped. Each entry holds a valid bit, a tag, a target and
// a 2-bit saturating counter. The table is looked up combinationally in F.
// The prediction is carried through F->D->E, where it is compared with the
// resolved branch. The table is written at the clock edge that closes E.
//   clk, reset : clock, asynchronous active-high reset
//   bp (slave) : PCF/StallD/FlushD/FlushE/BranchE/BranchTakenE/BranchTargetE in;
//                PredTakenF/PredTargetF/WrongPredictionE/CorrectPCE out
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    // BTB storage
    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [PC_W-1:0]  target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    // F->D and D->E prediction registers
    logic             v_d_q, v_d_d;
    logic [PC_W-1:0]  pc_d_q, pc_d_d;
    logic             pred_taken_d_q, pred_taken_d_d;
    logic [PC_W-1:0]  pred_target_d_q, pred_target_d_d;
    logic             v_e_q, v_e_d;
    logic [PC_W-1:0]  pc_e_q, pc_e_d;
    logic             pred_taken_e_q, pred_taken_e_d;
    logic [PC_W-1:0]  pred_target_e_q, pred_target_e_d;

    // F lookup
    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;
    logic             pred_taken_f;

    assign idx_f        = bp.PCF[IDX_W+1:2];
    assign tag_f        = bp.PCF[PC_W-1:IDX_W+2];
    assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_taken_f = hit_f && ctr_q[idx_f][1];

    assign bp.PredTakenF  = pred_taken_f;
    assign bp.PredTargetF = pred_taken_f ? target_q[idx_f] : bp.PCF + PC_W'(4);

    // E check
    logic [IDX_W-1:0] idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             hit_e;
    logic             mispredict_e;

    assign idx_e = pc_e_q[IDX_W+1:2];
    assign tag_e = pc_e_q[PC_W-1:IDX_W+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    always_comb begin
        mispredict_e = 1'b0;
        if (v_e_q) begin
            if (bp.BranchE) begin
                if (bp.BranchTakenE != pred_taken_e_q)
                    mispredict_e = 1'b1;
                else if (bp.BranchTakenE && (bp.BranchTargetE != pred_target_e_q))
                    mispredict_e = 1'b1;
            end else if (pred_taken_e_q) begin
                // A non-branch that hit the BTB: a stale alias entry.
                mispredict_e = 1'b1;
            end
        end
    end

    assign bp.WrongPredictionE = mispredict_e;
    assign bp.CorrectPCE = !mispredict_e ? '0 :
                           (bp.BranchE && bp.BranchTakenE) ? bp.BranchTargetE :
                           pc_e_q + PC_W'(4);

    // Pipeline register next state
    always_comb begin
        v_d_d           = v_d_q;
        pc_d_d          = pc_d_q;
        pred_taken_d_d  = pred_taken_d_q;
        pred_target_d_d = pred_target_d_q;
        if (bp.FlushD) begin
            v_d_d = 1'b0;
        end else if (!bp.StallD) begin
            v_d_d           = 1'b1;
            pc_d_d          = bp.PCF;
            pred_taken_d_d  = pred_taken_f;
            pred_target_d_d = bp.PredTargetF;
        end

        v_e_d           = bp.FlushE ? 1'b0 : v_d_q;
        pc_e_d          = pc_d_q;
        pred_taken_e_d  = pred_taken_d_q;
        pred_target_e_d = pred_target_d_q;
    end

    // Table update; flushes never suppress it
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (v_e_q) begin
            if (bp.BranchE) begin
                if (hit_e) begin
                    if (bp.BranchTakenE) begin
                        if (ctr_q[idx_e] != 2'b11)
                            ctr_d[idx_e] = ctr_q[idx_e] + 2'b01;
                        target_d[idx_e] = bp.BranchTargetE;
                    end else if (ctr_q[idx_e] != 2'b00) begin
                        ctr_d[idx_e] = ctr_q[idx_e] - 2'b01;
                    end
                end else if (bp.BranchTakenE) begin
                    valid_d[idx_e]  = 1'b1;
                    tag_d[idx_e]    = tag_e;
                    target_d[idx_e] = bp.BranchTargetE;
                    ctr_d[idx_e]    = 2'b10;
                end
            end else if (pred_taken_e_q) begin
                valid_d[idx_e] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            v_d_q           <= 1'b0;
            pc_d_q          <= '0;
            pred_taken_d_q  <= 1'b0;
            pred_target_d_q <= '0;
            v_e_q           <= 1'b0;
            pc_e_q          <= '0;
            pred_taken_e_q  <= 1'b0;
            pred_target_e_q <= '0;
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            target_q        <= target_d;
            ctr_q           <= ctr_d;
            v_d_q           <= v_d_d;
            pc_d_q          <= pc_d_d;
            pred_taken_d_q  <= pred_taken_d_d;
            pred_target_d_q <= pred_target_d_d;
            v_e_q           <= v_e_d;
            pc_e_q          <= pc_e_d;
            pred_taken_e_q  <= pred_taken_e_d;
            pred_target_e_q <= pred_target_e_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (ENTRIES=16, PC_W=32).
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] NOP_PC = 32'h0000_0404;

    branch_predictor_if #(.PC_W(32)) bp_if ();

    branch_predictor #(.ENTRIES(16), .PC_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_e();
        bp_if.BranchE       = 1'b0;
        bp_if.BranchTakenE  = 1'b0;
        bp_if.BranchTargetE = 32'h0;
    endtask

    // Combinational F lookup. PCF is returned to NOP_PC before any edge,
    // so the probe never enters the pipeline.
    task automatic check_pred(input logic [31:0] pc, input logic exp_t,
                              input logic [31:0] exp_tgt, input string name);
        bp_if.PCF = pc;
        #1;
        checks++;
        if (bp_if.PredTakenF !== exp_t) begin
            errors++;
            $display("FAIL %s PredTakenF got %0b expected %0b", name, bp_if.PredTakenF, exp_t);
        end
        checks++;
        if (bp_if.PredTargetF !== exp_tgt) begin
            errors++;
            $display("FAIL %s PredTargetF got %h expected %h", name, bp_if.PredTargetF, exp_tgt);
        end
        bp_if.PCF = NOP_PC;
    endtask

    // Fetch pc, let it travel to E, resolve it there, and check the E outputs.
    // The resolving edge writes the table.
    task automatic run_branch(input logic [31:0] pc, input logic br, input logic tk,
                              input logic [31:0] tgt, input logic exp_w,
                              input logic [31:0] exp_c, input string name);
        bp_if.PCF = pc;
        step();
        bp_if.PCF = NOP_PC;
        step();
        bp_if.BranchE       = br;
        bp_if.BranchTakenE  = tk;
        bp_if.BranchTargetE = tgt;
        #1;
        checks++;
        if (bp_if.WrongPredictionE !== exp_w) begin
            errors++;
            $display("FAIL %s WrongPredictionE got %0b expected %0b", name, bp_if.WrongPredictionE, exp_w);
        end
        checks++;
        if (bp_if.CorrectPCE !== exp_c) begin
            errors++;
            $display("FAIL %s CorrectPCE got %h expected %h", name, bp_if.CorrectPCE, exp_c);
        end
        step();
        clear_e();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bp_if.PCF    = 32'h100;
        bp_if.StallD = 1'b0;
        bp_if.FlushD = 1'b0;
        bp_if.FlushE = 1'b0;
        clear_e();
        step();
        step();
        checks++;
        if (bp_if.PredTakenF !== 1'b0 || bp_if.PredTargetF !== 32'h104) begin
            errors++;
            $display("FAIL reset_pred got %0b/%h expected 0/00000104", bp_if.PredTakenF, bp_if.PredTargetF);
        end
        checks++;
        if (bp_if.WrongPredictionE !== 1'b0 || bp_if.CorrectPCE !== 32'h0) begin
            errors++;
            $display("FAIL reset_e got %0b/%h expected 0/00000000", bp_if.WrongPredictionE, bp_if.CorrectPCE);
        end
        reset = 1'b0;
        bp_if.PCF = NOP_PC;
        step();
    endtask

    // First pass of a taken branch allocates the entry with counter 10.
    // A same-index fetch in the resolving cycle must still see the old table.
    task automatic test_train();
        bp_if.PCF = 32'h100;
        step();
        bp_if.PCF = NOP_PC;
        step();
        bp_if.BranchE       = 1'b1;
        bp_if.BranchTakenE  = 1'b1;
        bp_if.BranchTargetE = 32'h200;
        bp_if.PCF           = 32'h100;
        #1;
        checks++;
        if (bp_if.WrongPredictionE !== 1'b1 || bp_if.CorrectPCE !== 32'h200) begin
            errors++;
            $display("FAIL train_first got %0b/%h expected 1/00000200", bp_if.WrongPredictionE, bp_if.CorrectPCE);
        end
        checks++;
        if (bp_if.PredTakenF !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_lookup PredTakenF got %0b expected 0", bp_if.PredTakenF);
        end
        step();
        clear_e();
        check_pred(32'h100, 1'b1, 32'h200, "train_refetch");
        step();
    endtask

    task automatic test_counter();
        run_branch(32'h100, 1, 1, 32'h200, 0, 32'h0,   "ctr_t1");
        run_branch(32'h100, 1, 1, 32'h200, 0, 32'h0,   "ctr_t2_sat");
        run_branch(32'h100, 1, 0, 32'h0,   1, 32'h104, "ctr_nt1");
        check_pred(32'h100, 1'b1, 32'h200, "ctr_after_nt1");
        run_branch(32'h100, 1, 0, 32'h0,   1, 32'h104, "ctr_nt2");
        check_pred(32'h100, 1'b0, 32'h104, "ctr_after_nt2");
        run_branch(32'h100, 1, 0, 32'h0,   0, 32'h0,   "ctr_nt3_sat");
        run_branch(32'h100, 1, 1, 32'h200, 1, 32'h200, "ctr_up1");
        check_pred(32'h100, 1'b0, 32'h104, "ctr_floor_held");
        run_branch(32'h100, 1, 1, 32'h200, 1, 32'h200, "ctr_up2");
        check_pred(32'h100, 1'b1, 32'h200, "ctr_retaken");
        run_branch(32'h100, 1, 1, 32'h300, 1, 32'h300, "target_mismatch");
        check_pred(32'h100, 1'b1, 32'h300, "target_updated");
    endtask

    task automatic test_stall_flush();
        bp_if.PCF = 32'h100;
        step();
        bp_if.StallD = 1'b1;
        bp_if.FlushE = 1'b1;
        bp_if.PCF    = NOP_PC;
        for (int i = 0; i < 2; i++) begin
            step();
            bp_if.BranchE       = 1'b1;
            bp_if.BranchTakenE  = 1'b1;
            bp_if.BranchTargetE = 32'h500;
            #1;
            checks++;
            if (bp_if.WrongPredictionE !== 1'b0 || bp_if.CorrectPCE !== 32'h0) begin
                errors++;
                $display("FAIL stall_bubble_%0d got %0b/%h expected 0/00000000", i,
                         bp_if.WrongPredictionE, bp_if.CorrectPCE);
            end
        end
        bp_if.StallD = 1'b0;
        bp_if.FlushE = 1'b0;
        clear_e();
        step();
        // E now holds the stalled 0x100, predicted taken to 0x300.
        bp_if.BranchE       = 1'b1;
        bp_if.BranchTakenE  = 1'b1;
        bp_if.BranchTargetE = 32'h300;
        #1;
        checks++;
        if (bp_if.WrongPredictionE !== 1'b0) begin
            errors++;
            $display("FAIL stall_held_d WrongPredictionE got %0b expected 0", bp_if.WrongPredictionE);
        end
        step();
        clear_e();
        check_pred(32'h100, 1'b1, 32'h300, "bubble_no_update");

        bp_if.PCF    = 32'h100;
        bp_if.FlushD = 1'b1;
        step();
        bp_if.FlushD = 1'b0;
        bp_if.PCF    = NOP_PC;
        step();
        checks++;
        if (bp_if.WrongPredictionE !== 1'b0) begin
            errors++;
            $display("FAIL flushd_bubble WrongPredictionE got %0b expected 0", bp_if.WrongPredictionE);
        end
        step();
    endtask

    task automatic test_alias();
        run_branch(32'h100, 0, 0, 32'h0, 1, 32'h104, "alias");
        check_pred(32'h100, 1'b0, 32'h104, "alias_cleared");
    endtask

    task automatic test_async_reset();
        run_branch(32'h100, 1, 1, 32'h200, 1, 32'h200, "retrain");
        bp_if.PCF = 32'h100;
        step();
        bp_if.PCF = NOP_PC;
        step();
        checks++;
        if (bp_if.WrongPredictionE !== 1'b1 || bp_if.CorrectPCE !== 32'h104) begin
            errors++;
            $display("FAIL pre_reset_alias got %0b/%h expected 1/00000104", bp_if.WrongPredictionE, bp_if.CorrectPCE);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bp_if.WrongPredictionE !== 1'b0 || bp_if.CorrectPCE !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_e got %0b/%h expected 0/00000000", bp_if.WrongPredictionE, bp_if.CorrectPCE);
        end
        check_pred(32'h100, 1'b0, 32'h104, "async_reset_table");
        reset = 1'b0;
        step();
    endtask

    initial begin
        bp_if.PCF = NOP_PC;
        test_reset();
        test_train();
        test_counter();
        test_stall_flush();
        test_alias();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end
endmodule
